// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
// Multiplexed 4-digit 7-segment (FND) driver. A free-running scan counter
// steps through the four digits, with SCAN_DIV clocks per digit. Once per
// frame, at the end of digit 3, the binary input is sampled. It is then
// converted to BCD by a 14-step double-dabble sequencer and loaded into the
// display registers. Values above 9999 show dashes on every digit.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   seg_data  : 14-bit unsigned value to display (0..16383)
//   dp        : decimal-point request for digit DP_DIGIT
//   seg       : registered, active-low segments {dp,g,f,e,d,c,b,a}
//   an        : registered, active-low anode select, an[0] = ones digit
//   busy      : high while a conversion is in progress (SHIFT or LOAD)
//   dbg_state : current conversion FSM state (0 IDLE, 1 SHIFT, 2 LOAD)
module fnd_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int DP_DIGIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] seg_data,
  input  logic        dp,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Double-dabble correction: add 3 to every nibble that is 5 or more, so
  // the following left shift carries correctly into the next decade.
  function automatic logic [15:0] dd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low decode of a BCD digit onto segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             term;
  logic             frame_tick;

  // Conversion state
  state_t           state_q, state_d;
  logic [13:0]      shreg_q, shreg_d;
  logic             dp_cap_q, dp_cap_d;
  logic             over_cap_q, over_cap_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      scratch_adj;

  // Display state
  logic [15:0]      bcd_q, bcd_d;
  logic             dp_disp_q, dp_disp_d;
  logic             over_q, over_d;

  // Output registers
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       nib;

  assign term        = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_tick  = term && (digit_q == 2'd3);
  assign scratch_adj = dd_adjust(scratch_q);

  always_comb begin
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    state_d    = state_q;
    shreg_d    = shreg_q;
    dp_cap_d   = dp_cap_q;
    over_cap_d = over_cap_q;
    scratch_d  = scratch_q;
    bit_cnt_d  = bit_cnt_q;
    bcd_d      = bcd_q;
    dp_disp_d  = dp_disp_q;
    over_d     = over_q;

    if (term) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A frame tick outside IDLE is simply not looked at.
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          shreg_d    = seg_data;
          dp_cap_d   = dp;
          over_cap_d = (seg_data > 14'd9999);
          scratch_d  = '0;
          bit_cnt_d  = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = {scratch_adj[14:0], shreg_q[13]};
        shreg_d   = {shreg_q[12:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd13) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bcd_d     = scratch_q;
        dp_disp_d = dp_cap_q;
        over_d    = over_cap_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next-state values so seg/an always agree
    // with the registered digit index and the freshly loaded display.
    case (digit_d)
      2'd0:    nib = bcd_d[3:0];
      2'd1:    nib = bcd_d[7:4];
      2'd2:    nib = bcd_d[11:8];
      default: nib = bcd_d[15:12];
    endcase
    an_d       = ~(4'b0001 << digit_d);
    seg_d[6:0] = over_d ? 7'h3F : seg7(nib);
    seg_d[7]   = !((int'(digit_d) == DP_DIGIT) && dp_disp_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      digit_q    <= '0;
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      dp_cap_q   <= 1'b0;
      over_cap_q <= 1'b0;
      scratch_q  <= '0;
      bit_cnt_q  <= '0;
      bcd_q      <= '0;
      dp_disp_q  <= 1'b0;
      over_q     <= 1'b0;
      seg_q      <= 8'hC0;
      an_q       <= 4'b1110;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      dp_cap_q   <= dp_cap_d;
      over_cap_q <= over_cap_d;
      scratch_q  <= scratch_d;
      bit_cnt_q  <= bit_cnt_d;
      bcd_q      <= bcd_d;
      dp_disp_q  <= dp_disp_d;
      over_q     <= over_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

  localparam int SCAN_DIV = 16;
  localparam int DP_DIGIT = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] seg_data = '0;
  logic        dp = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  // Clock edges seen since the last reset release.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  fnd_scan_driver #(.SCAN_DIV(SCAN_DIV), .DP_DIGIT(DP_DIGIT)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .seg_data  (seg_data),
    .dp        (dp),
    .seg       (seg),
    .an        (an),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Expected segment byte for digit d when value v with decimal point dpv
  // is on display.
  function automatic logic [7:0] exp_seg(int v, bit dpv, int d);
    int         pw;
    logic [6:0] g;
    logic       dpb;
    pw  = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
    g   = (v > 9999) ? 7'h3F : seg_lut[(v / pw) % 10];
    dpb = (d == DP_DIGIT && dpv) ? 1'b0 : 1'b1;
    return {dpb, g};
  endfunction

  function automatic logic [31:0] exp_frame(int v, bit dpv);
    return {exp_seg(v, dpv, 3), exp_seg(v, dpv, 2),
            exp_seg(v, dpv, 1), exp_seg(v, dpv, 0)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit stop_mon = 1'b0;
  bit mon_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_busy(input logic level, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (busy !== level) begin
      if (n >= budget) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [31:0] exp;
    int          hi;
    int          n;
    @(posedge rst_n);
    while (!stop_mon) begin
      n = 0;
      while (busy !== 1'b1 && !stop_mon && n < 4 * FRAME) begin
        @(negedge clk);
        n++;
      end
      if (stop_mon) break;
      if (n >= 4 * FRAME) begin
        check("busy_rise_timeout", 0, 1);
        break;
      end
      // Conversion starts on the edge right after a frame tick.
      check("busy_rise_phase", cyc % FRAME, 0);
      hi = 0;
      while (busy === 1'b1 && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      check("busy_len", hi, 15);
      if (exp_q.size() == 0) begin
        check("sb_empty", 0, 1);
        continue;
      end
      exp = exp_q.pop_front();
      // Digit 0 is on its last cycle when the load lands; then sample the
      // last cycle of each following digit slot.
      for (int d = 0; d < 4; d++) begin
        if (d != 0) repeat (SCAN_DIV) @(negedge clk);
        check($sformatf("an_d%0d", d), {28'd0, an}, {28'd0, ~(4'b0001 << d)});
        check($sformatf("seg_d%0d", d), {24'd0, seg}, {24'd0, exp[8*d +: 8]});
      end
    end
    mon_done = 1'b1;
  end

  // ---------------- driver ----------------
  int vals[$];
  bit dps[$];

  task automatic apply(input int v, input bit dpv);
    seg_data = 14'(v);
    dp       = dpv;
  endtask

  initial begin : driver
    bit ok;
    int n;
    int e_an;

    vals = '{1234, 9999, 10000, 11111, 523, 5, 7, 0, 16383, 9998};
    dps  = '{0,    0,    0,     1,     1,   0, 0, 1, 1,     1};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) vals.push_back($urandom_range(9990, 10010));
      else       vals.push_back($urandom_range(0, 16383));
      dps.push_back(1'($urandom_range(0, 1)));
    end

    // Reset state
    apply(vals[0], dps[0]);
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hE);
    check("rst_seg", {24'd0, seg}, 32'hC0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    rst_n = 1'b1;

    // Before the first frame tick the display shows zeros.
    repeat (SCAN_DIV + 3) @(negedge clk);
    check("pre_busy", {31'd0, busy}, 0);
    check("pre_an", {28'd0, an}, 32'hD);
    check("pre_seg", {24'd0, seg}, 32'hC0);

    for (int i = 0; i < vals.size(); i++) begin
      wait_busy(1'b1, 4 * FRAME, ok);
      if (!ok) begin
        check("drv_rise_timeout", 0, 1);
        break;
      end
      exp_q.push_back(exp_frame(vals[i], dps[i]));
      wait_busy(1'b0, 40, ok);
      if (!ok) begin
        check("drv_fall_timeout", 0, 1);
        break;
      end
      // Next value arrives mid-frame; it must not disturb the display
      // until the following conversion.
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if (i + 1 < vals.size()) apply(vals[i + 1], dps[i + 1]);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", exp_q.size(), 0);
    stop_mon = 1'b1;
    n = 0;
    while (!mon_done && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("mon_done", {31'd0, mon_done}, 1);

    // Reset during SHIFT: immediate return to the reset state, no partial
    // result on the display afterwards.
    apply(8888, 1'b1);
    wait_busy(1'b1, 4 * FRAME, ok);
    check("rst_test_rise", {31'd0, ok}, 1);
    repeat (3) @(negedge clk);
    check("mid_state_shift", {30'd0, dbg_state}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_an", {28'd0, an}, 32'hE);
    check("mid_rst_seg", {24'd0, seg}, 32'hC0);
    check("mid_rst_state", {30'd0, dbg_state}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < FRAME - 2; k++) begin
      @(negedge clk);
      e_an = 4'hF & ~(1 << ((cyc / SCAN_DIV) % 4));
      check("post_an", {28'd0, an}, 32'(e_an));
      check("post_seg", {24'd0, seg}, 32'hC0);
      check("post_busy", {31'd0, busy}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
